hp_round_ctrl: RTL

Round sequencer and HP manager for the two-player factorization duel. Consumes the registered win/lose code from the answer-race judge, applies damage to both players' HP, runs the per-question countdown, and gates answer entry. It also requests new questions and declares the match winner. Sits between the judge and the display/question-generator blocks.

---
 rtl/hp_round_if.sv | 30 +++
 rtl/hp_round_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hp_round_if.sv
// Bundle between the round sequencer and its surroundings: judge/time-base inputs
// and the registered HP, timer and round status outputs.
interface hp_round_if #(
    parameter int HP_W    = 3,
    parameter int T_W     = 5,
    parameter int ROUND_W = 5
);
    logic               start;
    logic               tick;
    logic [1:0]         wl;
    logic               ans_en;
    logic               q_req;
    logic [HP_W-1:0]    my_hp;
    logic [HP_W-1:0]    en_hp;
    logic [T_W-1:0]     timer;
    logic [ROUND_W-1:0] round;
    logic [1:0]         last;
    logic [1:0]         state;
    logic [1:0]         winner;

    modport master (
        output start, tick, wl,
        input  ans_en, q_req, my_hp, en_hp, timer, round, last, state, winner
    );

    modport slave (
        input  start, tick, wl,
        output ans_en, q_req, my_hp, en_hp, timer, round, last, state, winner
    );
endinterface

// File: rtl/hp_round_ctrl.sv
// Round sequencer for the factorization duel: applies judge results to both HP
// registers, runs the per-question countdown and declares the match winner.
module hp_round_ctrl #(
    parameter int HP_INIT     = 5,
    parameter int HP_W        = 3,
    parameter int DMG         = 1,
    parameter int TIME_LIMIT  = 30,
    parameter int T_W         = 5,
    parameter int RESULT_HOLD = 3,
    parameter int ROUND_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    hp_round_if.slave  bus
);
    localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        QUESTION = 2'b01,
        RESULT   = 2'b10,
        GAMEOVER = 2'b11
    } state_t;

    typedef struct packed {
        state_t             state;
        logic               ans_en;
        logic               q_req;
        logic [HP_W-1:0]    my_hp;
        logic [HP_W-1:0]    en_hp;
        logic [T_W-1:0]     timer;
        logic [ROUND_W-1:0] round;
        logic [1:0]         last;
        logic [1:0]         winner;
        logic [HOLD_W-1:0]  hold;
    } regs_t;

    regs_t cur, nxt;

    // Damage never wraps: an HP below DMG clamps to zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
        return (hp > HP_W'(DMG)) ? hp - HP_W'(DMG) : '0;
    endfunction

    // NOTE: the state register uses <= so every field samples the pre-edge view of nxt.
    always_ff @(posedge clk) begin
        if (rst) cur <= '0;
        else     cur <= nxt;
    end

    always_comb begin
        // NOTE: start from the held value so no path through this block infers a latch.
        nxt       = cur;
        nxt.q_req = 1'b0;

        unique case (cur.state)
            IDLE, GAMEOVER: begin
                if (bus.start) begin
                    nxt.state  = QUESTION;
                    nxt.my_hp  = HP_W'(HP_INIT);
                    nxt.en_hp  = HP_W'(HP_INIT);
                    nxt.round  = ROUND_W'(1);
                    nxt.timer  = T_W'(TIME_LIMIT);
                    nxt.last   = 2'b00;
                    nxt.winner = 2'b00;
                    nxt.q_req  = 1'b1;
                    nxt.hold   = '0;
                end
            end

            QUESTION: begin
                // A judge result wins over a coincident timeout and freezes the timer.
                if (bus.wl != 2'b00) begin
                    if (bus.wl[0]) nxt.en_hp = sat_sub(cur.en_hp);
                    if (bus.wl[1]) nxt.my_hp = sat_sub(cur.my_hp);
                    nxt.last  = bus.wl;
                    nxt.state = RESULT;
                    nxt.hold  = '0;
                end else if (bus.tick) begin
                    if (cur.timer == T_W'(1)) begin
                        nxt.timer = '0;
                        nxt.last  = 2'b00;
                        nxt.state = RESULT;
                        nxt.hold  = '0;
                    end else begin
                        nxt.timer = cur.timer - 1'b1;
                    end
                end
            end

            RESULT: begin
                if (bus.tick) begin
                    if (cur.hold == HOLD_W'(RESULT_HOLD - 1)) begin
                        if (cur.my_hp == '0 || cur.en_hp == '0) begin
                            nxt.state  = GAMEOVER;
                            nxt.winner = {cur.my_hp == '0, cur.en_hp == '0};
                        end else begin
                            nxt.state = QUESTION;
                            if (cur.round != '1) nxt.round = cur.round + 1'b1;
                            nxt.timer = T_W'(TIME_LIMIT);
                            nxt.q_req = 1'b1;
                        end
                    end else begin
                        nxt.hold = cur.hold + 1'b1;
                    end
                end
            end

            default: nxt = cur;
        endcase

        nxt.ans_en = (nxt.state == QUESTION);
    end

    assign bus.state  = cur.state;
    assign bus.ans_en = cur.ans_en;
    assign bus.q_req  = cur.q_req;
    assign bus.my_hp  = cur.my_hp;
    assign bus.en_hp  = cur.en_hp;
    assign bus.timer  = cur.timer;
    assign bus.round  = cur.round;
    assign bus.last   = cur.last;
    assign bus.winner = cur.winner;
endmodule
